display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 33 +++
 rtl/seg7_decode3.sv | 19 +
 rtl/display_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared definitions for the multiplexed 7-segment display scanner.
//             Holds the scan FSM state encoding, the digit geometry and the
//             3-bit value to {g,f,e,d,c,b,a} glyph table.
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 3;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_t;

    // Active-high segments, bit order {g,f,e,d,c,b,a}; entry v is glyph for v.
    localparam logic [7:0][6:0] C_GLYPH_TABLE = {
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_decode3.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode3
//  Purpose  : Combinational 3-bit value to 7-segment glyph decoder.
//  Ports    : i_value [2:0] - digit value 0..7
//             o_seg   [6:0] - segments {g,f,e,d,c,b,a}, active-high
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decode3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_value,
    output logic [6:0]         o_seg
);

    assign o_seg = C_GLYPH_TABLE[i_value];

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_ctrl
//  Purpose  : Time-multiplexed scanner for a 4-digit 7-segment display. Each
//             digit is driven for DIV_CYCLES clocks followed by GUARD_CYCLES
//             all-off clocks. New display values are double-buffered and only
//             committed at a frame boundary (or immediately while scanning is
//             off), so a frame never shows a mix of old and new digits.
//  Ports    : clk, rst_n (sync, active-low), en (scan enable)
//             load_valid/load_data/load_dp/load_ready - value load handshake
//             seg/dp/digit_en - registered display drive
//             frame_done - one-clock pulse on the last clock of each frame
//  Options  : LEADING_ZERO_BLANK_EN - blank leading zero digits 3..1
//  Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV_CYCLES   = 1000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load_valid,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]         load_dp,
    output logic                          load_ready,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_done
);

    localparam logic [15:0] C_DIV_LAST   = 16'(DIV_CYCLES - 1);
    localparam logic [15:0] C_GUARD_LAST = 16'(GUARD_CYCLES - 1);

    scan_state_t                   r_state;
    scan_state_t                   w_state_nxt;
    logic [1:0]                    r_digit;
    logic [1:0]                    w_digit_nxt;
    logic [15:0]                   r_cnt;
    logic [15:0]                   w_cnt_nxt;

    logic [NUM_DIGITS*DIGIT_W-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]         r_act_dp;
    logic [NUM_DIGITS*DIGIT_W-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]         r_pend_dp;
    logic                          r_pend_full;

    logic [6:0]                    r_seg;
    logic                          r_dp;
    logic [NUM_DIGITS-1:0]         r_digit_en;

    logic                          w_frame_end;
    logic                          w_commit;
    logic                          w_accept;
    logic [NUM_DIGITS*DIGIT_W-1:0] w_act_data_nxt;
    logic [NUM_DIGITS-1:0]         w_act_dp_nxt;
    logic [DIGIT_W-1:0]            w_digit_val;
    logic [6:0]                    w_glyph;
    logic                          w_blank;
    logic [NUM_DIGITS-1:0]         w_digit_en_nxt;

    // ------------------------------------------------------------------
    // Scan sequencing: next state, digit index and cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_cnt_nxt   = r_cnt;
        if (!en) begin
            w_state_nxt = ST_OFF;
            w_digit_nxt = 2'd0;
            w_cnt_nxt   = 16'd0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_DRIVE;
                    w_digit_nxt = 2'd0;
                    w_cnt_nxt   = 16'd0;
                end
                ST_DRIVE: begin
                    if (r_cnt == C_DIV_LAST) begin
                        w_state_nxt = ST_GUARD;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 16'd1;
                    end
                end
                ST_GUARD: begin
                    if (r_cnt == C_GUARD_LAST) begin
                        w_state_nxt = ST_DRIVE;
                        w_digit_nxt = r_digit + 2'd1;   // 2-bit index wraps 3 -> 0
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_digit_nxt = 2'd0;
                    w_cnt_nxt   = 16'd0;
                end
            endcase
        end
    end

    // Last GUARD clock of digit 3 is the frame boundary.
    assign w_frame_end = (r_state == ST_GUARD) && (r_digit == 2'd3) &&
                         (r_cnt == C_GUARD_LAST);

    // While scanning is off there is no frame to tear, so commit at once.
    assign w_commit = r_pend_full && ((r_state == ST_OFF) || w_frame_end);
    // Pending full blocks acceptance, so accept and commit never coincide.
    assign w_accept = load_valid && !r_pend_full;

    // The registered outputs are built from the post-edge view so that the
    // first DRIVE clock after a commit already shows the new value.
    assign w_act_data_nxt = w_commit ? r_pend_data : r_act_data;
    assign w_act_dp_nxt   = w_commit ? r_pend_dp   : r_act_dp;
    assign w_digit_val    = w_act_data_nxt[int'(w_digit_nxt)*DIGIT_W +: DIGIT_W];
    assign w_digit_en_nxt = 4'b0001 << w_digit_nxt;

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero.
    assign w_blank = (w_digit_nxt != 2'd0) &&
                     ((w_act_data_nxt >> (int'(w_digit_nxt)*DIGIT_W)) == '0);
`else
    assign w_blank = 1'b0;
`endif

    seg7_decode3 u_seg7_decode3 (
        .i_value (w_digit_val),
        .o_seg   (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_digit     <= 2'd0;
            r_cnt       <= 16'd0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_full <= 1'b0;
            r_seg       <= 7'd0;
            r_dp        <= 1'b0;
            r_digit_en  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_digit    <= w_digit_nxt;
            r_cnt      <= w_cnt_nxt;
            r_act_data <= w_act_data_nxt;
            r_act_dp   <= w_act_dp_nxt;

            if (w_accept) begin
                r_pend_data <= load_data;
                r_pend_dp   <= load_dp;
                r_pend_full <= 1'b1;
            end else if (w_commit) begin
                r_pend_full <= 1'b0;
            end

            if (w_state_nxt == ST_DRIVE) begin
                r_digit_en <= w_digit_en_nxt;
                r_seg      <= w_blank ? 7'd0 : w_glyph;
                r_dp       <= w_act_dp_nxt[w_digit_nxt];
            end else begin
                r_digit_en <= '0;
                r_seg      <= 7'd0;
                r_dp       <= 1'b0;
            end
        end
    end

    assign load_ready = !r_pend_full;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign digit_en   = r_digit_en;
    assign frame_done = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan_ctrl
//  Purpose  : Self-checking bench for display_scan_ctrl (DIV_CYCLES=4,
//             GUARD_CYCLES=1). The reference model tracks the position inside
//             a 20-clock frame plus the active/pending display values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load_valid = 1'b0;
    logic [11:0] load_data = '0;
    logic [3:0]  load_dp = '0;
    logic        load_ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scan_ctrl #(.DIV_CYCLES(4), .GUARD_CYCLES(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (load_ready),
        .seg        (seg),
        .dp         (dp),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_pos = -1 when off, else clock position 0..19 in frame.
    int          m_pos = -1;
    logic [11:0] m_act = '0, m_pend = '0;
    logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
    bit          m_ready = 1'b1;

    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_den;
    logic        exp_fd;
    logic        exp_ready;

    function automatic logic [6:0] ref_glyph(input int v);
        case (v)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            default: return 7'b0000111;
        endcase
    endfunction

    // Advance one clock, update the model from the sampled inputs, then
    // compute the outputs the DUT should present after that edge.
    task automatic tick();
        bit commit;
        int d;
        @(posedge clk);
        if (!rst_n) begin
            m_pos = -1; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0;
            m_ready = 1'b1;
        end else begin
            commit = !m_ready && (m_pos < 0 || m_pos == 19);
            if (commit) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_ready = 1'b1;
            end else if (load_valid && m_ready) begin
                m_pend = load_data; m_pend_dp = load_dp; m_ready = 1'b0;
            end
            if (!en)             m_pos = -1;
            else if (m_pos < 0)  m_pos = 0;
            else                 m_pos = (m_pos + 1) % 20;
        end
        #1;
        exp_fd    = (m_pos == 19);
        exp_ready = m_ready;
        if (m_pos >= 0 && (m_pos % 5) < 4) begin
            d       = m_pos / 5;
            exp_den = 4'b0001 << d;
            exp_seg = ref_glyph(int'(m_act[d*3 +: 3]));
            exp_dp  = m_act_dp[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (m_act >> (d*3)) == 12'd0) exp_seg = 7'd0;
`endif
        end else begin
            exp_den = 4'd0; exp_seg = 7'd0; exp_dp = 1'b0;
        end
    endtask

    task automatic test_reset();
        int last, pulses;
        rst_n = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'($urandom); load_data = 12'($urandom);
            tick();
            n_checks++;
            if (seg !== 7'd0 || digit_en !== 4'd0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: seg=%b den=%b rdy=%b fd=%b, required 0000000 0000 1 0",
                         seg, digit_en, load_ready, frame_done);
            end
        end
        rst_n = 1'b1; load_valid = 1'b0;
        tick();
        n_checks++;
        if (seg !== 7'b0111111 || digit_en !== 4'b0001) begin
            n_fail++;
            $display("FAIL first_drive: seg=%b den=%b, required 0111111 0001", seg, digit_en);
        end
        last = -1; pulses = 0;
        for (int i = 0; i < 65; i++) begin
            tick();
            n_checks++;
            if ({seg, dp, digit_en, frame_done, load_ready} !== {exp_seg, exp_dp, exp_den, exp_fd, exp_ready}) begin
                n_fail++;
                $display("FAIL idle_model: seg=%b dp=%b den=%b fd=%b rdy=%b, required %b %b %b %b %b",
                         seg, dp, digit_en, frame_done, load_ready, exp_seg, exp_dp, exp_den, exp_fd, exp_ready);
            end
            if (frame_done === 1'b1) begin
                pulses++;
                if (last >= 0) begin
                    n_checks++;
                    if (i - last != 20) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d clocks, required 20", i - last);
                    end
                end
                last = i;
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL frame_pulses: got %0d pulses, required 3", pulses);
        end
    endtask

    task automatic test_load();
        logic [6:0] tbl [4] = '{7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};
        bit seen;
        int guard;
        guard = 0;
        while (exp_den !== 4'b0010 && guard < 25) begin tick(); guard++; end
        load_valid = 1'b1; load_data = 12'o7654; load_dp = 4'b0100;
        tick();
        load_data = 12'($urandom); load_dp = 4'($urandom);   // must be ignored
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_accept: load_ready=%b, required 0", load_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            n_checks++;
            if ({seg, dp, digit_en, frame_done, load_ready} !== {exp_seg, exp_dp, exp_den, exp_fd, exp_ready}) begin
                n_fail++;
                $display("FAIL load_model: seg=%b dp=%b den=%b fd=%b rdy=%b, required %b %b %b %b %b",
                         seg, dp, digit_en, frame_done, load_ready, exp_seg, exp_dp, exp_den, exp_fd, exp_ready);
            end
            if (frame_done === 1'b1) begin seen = 1'b1; load_valid = 1'b0; end
        end
        load_valid = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL load_frame_timeout: frame_done=0, required a pulse within 30 clocks");
        end
        tick();
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_frame: load_ready=%b, required 1", load_ready);
        end
        for (int d = 0; d < 4; d++) begin
            if (d > 0) for (int k = 0; k < 5; k++) tick();
            n_checks++;
            if (seg !== tbl[d] || digit_en !== (4'b0001 << d) || dp !== (d == 2)) begin
                n_fail++;
                $display("FAIL load_digit%0d: seg=%b den=%b dp=%b, required %b %b %b",
                         d, seg, digit_en, dp, tbl[d], 4'b0001 << d, d == 2);
            end
        end
    endtask

    task automatic test_timing();
        bit first;
        logic [3:0] oh;
        en = 1'b0; tick();
        en = 1'b1; tick();
        first = 1'b1;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            for (int c = 0; c < 4; c++) begin
                if (!first) tick();
                first = 1'b0;
                n_checks++;
                if (digit_en !== oh) begin
                    n_fail++;
                    $display("FAIL drive_len k=%0d c=%0d: digit_en=%b, required %b", k, c, digit_en, oh);
                end
            end
            if (k < 4) begin
                tick();
                n_checks++;
                if (digit_en !== 4'd0 || seg !== 7'd0 || dp !== 1'b0) begin
                    n_fail++;
                    $display("FAIL guard k=%0d: den=%b seg=%b dp=%b, required 0000 0000000 0", k, digit_en, seg, dp);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        int guard;
        guard = 0;
        while (digit_en !== 4'b0100 && guard < 30) begin tick(); guard++; end
        n_checks++;
        if (digit_en !== 4'b0100) begin
            n_fail++;
            $display("FAIL en_drop_wait: digit_en=%b, required 0100 within 30 clocks", digit_en);
        end
        tick();
        en = 1'b0; tick();
        n_checks++;
        if (digit_en !== 4'd0 || seg !== 7'd0 || dp !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_off: den=%b seg=%b dp=%b fd=%b, required all 0", digit_en, seg, dp, frame_done);
        end
        en = 1'b1; tick();
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            n_checks++;
            if (digit_en !== 4'b0001) begin
                n_fail++;
                $display("FAIL reenable_drive c=%0d: digit_en=%b, required 0001", c, digit_en);
            end
        end
        tick();
        n_checks++;
        if (digit_en !== 4'd0) begin
            n_fail++;
            $display("FAIL reenable_guard: digit_en=%b, required 0000", digit_en);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        load_valid = 1'b1; load_data = 12'($urandom); load_dp = 4'($urandom);
        tick();
        load_data = 12'($urandom); load_dp = 4'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            n_checks++;
            if (load_ready !== 1'b0 || {seg, dp, digit_en} !== {exp_seg, exp_dp, exp_den}) begin
                n_fail++;
                $display("FAIL b2b_hold: rdy=%b seg=%b dp=%b den=%b, required 0 %b %b %b",
                         load_ready, seg, dp, digit_en, exp_seg, exp_dp, exp_den);
            end
            if (frame_done === 1'b1) seen = 1'b1;
        end
        tick();
        n_checks++;
        if (load_ready !== 1'b1 || {seg, dp, digit_en} !== {exp_seg, exp_dp, exp_den}) begin
            n_fail++;
            $display("FAIL b2b_first_commit: rdy=%b seg=%b dp=%b den=%b, required 1 %b %b %b",
                     load_ready, seg, dp, digit_en, exp_seg, exp_dp, exp_den);
        end
        tick();
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: load_ready=%b, required 0", load_ready);
        end
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_checks++;
            if (load_ready !== 1'b1 || (digit_en !== 4'd0 && (seg !== 7'b0111111 || dp !== 1'b0))) begin
                n_fail++;
                $display("FAIL post_reset_zero: rdy=%b den=%b seg=%b dp=%b, required 1 and seg 0111111 dp 0",
                         load_ready, digit_en, seg, dp);
            end
        end
    endtask

    task automatic test_blank();
        logic [6:0] hi;
`ifdef LEADING_ZERO_BLANK_EN
        hi = 7'd0;
`else
        hi = 7'b0111111;
`endif
        en = 1'b0; tick();
        load_valid = 1'b1; load_data = 12'o0005; load_dp = 4'b0000;
        tick();
        load_valid = 1'b0;
        tick();
        en = 1'b1; tick();
        n_checks++;
        if (seg !== 7'b1101101 || digit_en !== 4'b0001) begin
            n_fail++;
            $display("FAIL blank_d0: seg=%b den=%b, required 1101101 0001", seg, digit_en);
        end
        for (int d = 1; d < 4; d++) begin
            for (int k = 0; k < 5; k++) tick();
            n_checks++;
            if (seg !== hi || digit_en !== (4'b0001 << d)) begin
                n_fail++;
                $display("FAIL blank_d%0d: seg=%b den=%b, required %b %b", d, seg, digit_en, hi, 4'b0001 << d);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            en         = ($urandom_range(0, 39) != 0);
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 12'($urandom);
            load_dp    = 4'($urandom);
            tick();
            n_checks++;
            if ({seg, dp, digit_en, frame_done, load_ready} !== {exp_seg, exp_dp, exp_den, exp_fd, exp_ready}) begin
                n_fail++;
                $display("FAIL random_model i=%0d: seg=%b dp=%b den=%b fd=%b rdy=%b, required %b %b %b %b %b",
                         i, seg, dp, digit_en, frame_done, load_ready, exp_seg, exp_dp, exp_den, exp_fd, exp_ready);
            end
        end
        rst_n = 1'b1; en = 1'b1; load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_timing();
        test_en_drop();
        test_back_to_back();
        test_blank();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
